// File: rtl/picorv_irq_ctrl.sv
// picorv_irq_ctrl: interrupt controller for the picorv32 irq/eoi interface.
// Supports per-line edge-latched or level capture, hard and software masking,
// write-1-clear pending bits and a one-shot down-counting timer interrupt.
// Registers are reached through a single-outstanding request/ready bus.
module picorv_irq_ctrl #(
  parameter int unsigned NUM_IRQ     = 32,
  parameter logic [31:0] MASKED_IRQ  = 32'h0000_0000,
  parameter logic [31:0] LATCHED_IRQ = 32'hffff_ffff,
  parameter int unsigned TIMER_IRQ   = 0,
  parameter int unsigned TIMER_WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [NUM_IRQ-1:0] eoi,
  output logic [NUM_IRQ-1:0] irq_out,
  input  logic               reg_valid,
  input  logic               reg_write,
  input  logic [3:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               reg_ready
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } busState_e;

  localparam logic [3:0] ADDR_MASK  = 4'h0;
  localparam logic [3:0] ADDR_PEND  = 4'h4;
  localparam logic [3:0] ADDR_TIMER = 4'h8;

  // Lines that can never reach the core.
  localparam logic [NUM_IRQ-1:0] HARD_MASK = MASKED_IRQ[NUM_IRQ-1:0];
  // Lines using latched capture; the timer line is always latched.
  localparam logic [NUM_IRQ-1:0] LATCH_SEL =
    LATCHED_IRQ[NUM_IRQ-1:0] | (NUM_IRQ'(1) << TIMER_IRQ);

  busState_e              state_q;
  logic [NUM_IRQ-1:0]     mask_q, mask_d;
  logic [NUM_IRQ-1:0]     pending_q, pending_d;
  logic [NUM_IRQ-1:0]     src_q;
  logic [NUM_IRQ-1:0]     irqOut_q;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [31:0]            rdata_q;
  logic                   ready_q;

  logic                   accessEn;
  logic                   wrMask, wrPend, wrTimer;
  logic                   timerFire;
  logic [NUM_IRQ-1:0]     timerSet, edgeSet, clrSet, latchedNext;
  logic [31:0]            rdataMux;

  // An access is taken only while idle; writes are decoded from it.
  always_comb begin
    accessEn = (state_q == ST_IDLE) && reg_valid;
    wrMask   = accessEn && reg_write && (reg_addr == ADDR_MASK);
    wrPend   = accessEn && reg_write && (reg_addr == ADDR_PEND);
    wrTimer  = accessEn && reg_write && (reg_addr == ADDR_TIMER);
  end

  // Read data selection, zero-extended; unmapped addresses read as zero.
  always_comb begin
    rdataMux = '0;
    case (reg_addr)
      ADDR_MASK:  rdataMux[NUM_IRQ-1:0]     = mask_q;
      ADDR_PEND:  rdataMux[NUM_IRQ-1:0]     = pending_q;
      ADDR_TIMER: rdataMux[TIMER_WIDTH-1:0] = timer_q;
      default:    rdataMux = '0;
    endcase
  end

  // Timer next state: a write wins over the decrement; reaching zero fires once.
  always_comb begin
    timer_d   = timer_q;
    timerFire = 1'b0;
    if (wrTimer) begin
      timer_d = reg_wdata[TIMER_WIDTH-1:0];
    end else if (timer_q != '0) begin
      timer_d   = timer_q - TIMER_WIDTH'(1);
      timerFire = (timer_q == TIMER_WIDTH'(1));
    end
  end

  // Pending next state: latched lines set on rising edge (set beats clear), level lines follow the source.
  always_comb begin
    timerSet    = NUM_IRQ'(timerFire) << TIMER_IRQ;
    edgeSet     = (irq_src & ~src_q) | timerSet;
    clrSet      = eoi | (wrPend ? reg_wdata[NUM_IRQ-1:0] : '0);
    latchedNext = edgeSet | (pending_q & ~clrSet);
    pending_d   = (latchedNext & LATCH_SEL) | (irq_src & ~LATCH_SEL);
    mask_d      = wrMask ? reg_wdata[NUM_IRQ-1:0] : mask_q;
  end

  // Interrupt state registers and the registered core-facing irq vector.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mask_q    <= '1;
      pending_q <= '0;
      src_q     <= '0;
      irqOut_q  <= '0;
      timer_q   <= '0;
    end else begin
      mask_q    <= mask_d;
      pending_q <= pending_d;
      src_q     <= irq_src;
      irqOut_q  <= pending_q & ~mask_q & ~HARD_MASK;
      timer_q   <= timer_d;
    end
  end

  // Register bus FSM: one access in IDLE, then a single ready pulse in RESP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (reg_valid) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
            rdata_q <= rdataMux;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq_out   = irqOut_q;
  assign reg_ready = ready_q;
  assign reg_rdata = rdata_q;

endmodule
